// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared grant tags, FSM states and default widths for the DS port arbiter
package dmem_port_arbiter_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ST   = 2'd1,
    GNT_LD   = 2'd2,
    GNT_DBG  = 2'd3
  } gnt_tag_e;

  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

  // Width that holds 0..max_v; never narrower than one bit.
  function automatic int age_width(input int max_v);
    int w;
    w = $clog2(max_v + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester, grant and DS memory-port bundle for the DS port arbiter
interface dmem_port_arbiter_if #(
  parameter int AW = dmem_port_arbiter_pkg::AW_DEF,
  parameter int DW = dmem_port_arbiter_pkg::DW_DEF
) ();

  logic          st_req;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic          st_half;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;

  logic          st_gnt;
  logic          ld_gnt;
  logic          dbg_gnt;
  logic [DW-1:0] ld_rdata;
  logic [DW-1:0] dbg_rdata;
  logic          ld_rvalid;
  logic          dbg_rvalid;
  logic          pipe_stall;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_half;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  st_req, st_addr, st_wdata, st_half, ld_req, ld_addr, dbg_req, dbg_addr, mem_rdata,
    output st_gnt, ld_gnt, dbg_gnt, ld_rdata, dbg_rdata, ld_rvalid, dbg_rvalid, pipe_stall,
           mem_we, mem_addr, mem_wdata, mem_half
  );

  // Requesters plus the DS read-data return.
  modport master (
    output st_req, st_addr, st_wdata, st_half, ld_req, ld_addr, dbg_req, dbg_addr, mem_rdata,
    input  st_gnt, ld_gnt, dbg_gnt, ld_rdata, dbg_rdata, ld_rvalid, dbg_rvalid, pipe_stall,
           mem_we, mem_addr, mem_wdata, mem_half
  );

endinterface

// File: rtl/dmem_port_arbiter_age_counter.sv
// rtl/dmem_port_arbiter_age_counter.sv - saturating wait-age counter for the pending debug read
module dmem_age_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 15
) (
  input  logic clk,
  input  logic in_RST,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam int W = age_width(STARVE_MAX);

  logic [W-1:0] age_q, age_d;

  assign at_max_o = (age_q == W'(STARVE_MAX));

  always_comb begin
    age_d = age_q;
    if (clr_i) begin
      age_d = '0;
    end else if (inc_i && !at_max_o) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_RST) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - DS port arbiter: store > load > debug, aged debug force-grant, pipeline stall
// Optional perf counters (stall_cnt, force_cnt) under `DMEM_ARB_PERF_CNT_EN.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 15
) (
  input  logic                 clk,
  input  logic                 in_RST,
  dmem_port_arbiter_if.slave   bus,
  output logic [31:0]          stall_cnt,
  output logic [15:0]          force_cnt
);

  arb_state_e    state_q, state_d;
  gnt_tag_e      tag_q, tag_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] dbg_addr_q, dbg_addr_d;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] ld_rdata_q, dbg_rdata_q;

  logic          st_gnt, ld_gnt, dbg_gnt;
  logic          pipe_stall;
  logic          at_max;
  logic [AW-1:0] mem_addr;
  logic          ld_rvalid, dbg_rvalid;
  logic [DW-1:0] ld_rdata, dbg_rdata;

  dmem_age_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_age (
    .clk      (clk),
    .in_RST   (in_RST),
    .clr_i    (dbg_gnt),
    .inc_i    (pending_q && !dbg_gnt),
    .at_max_o (at_max)
  );

  // Grants and next state. Everything is held quiet while reset is asserted.
  always_comb begin
    st_gnt  = 1'b0;
    ld_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    state_d = state_q;
    if (!in_RST) begin
      unique case (state_q)
        ARB: begin
          if (bus.st_req) begin
            st_gnt = 1'b1;
          end else if (bus.ld_req) begin
            ld_gnt = 1'b1;
          end else if (pending_q) begin
            dbg_gnt = 1'b1;
          end
          // A debug read served by priority this cycle no longer needs forcing.
          if (at_max && !dbg_gnt) begin
            state_d = FORCE;
          end
        end
        FORCE: begin
          dbg_gnt = 1'b1;
          state_d = ARB;
        end
      endcase
    end
  end

  assign pipe_stall = !in_RST && ((bus.st_req && !st_gnt) || (bus.ld_req && !ld_gnt));

  always_comb begin
    pending_d  = pending_q;
    dbg_addr_d = dbg_addr_q;
    if (dbg_gnt) begin
      pending_d = 1'b0;
    end else if (bus.dbg_req && !pending_q) begin
      pending_d  = 1'b1;
      dbg_addr_d = bus.dbg_addr;
    end
  end

  always_comb begin
    tag_d    = GNT_NONE;
    mem_addr = mem_addr_q;
    if (in_RST) begin
      mem_addr = '0;
    end else if (st_gnt) begin
      tag_d    = GNT_ST;
      mem_addr = bus.st_addr;
    end else if (ld_gnt) begin
      tag_d    = GNT_LD;
      mem_addr = bus.ld_addr;
    end else if (dbg_gnt) begin
      tag_d    = GNT_DBG;
      mem_addr = dbg_addr_q;
    end
  end

  // DS returns data one cycle after the address; the registered tag steers it.
  assign ld_rvalid  = !in_RST && (tag_q == GNT_LD);
  assign dbg_rvalid = !in_RST && (tag_q == GNT_DBG);
  assign ld_rdata   = in_RST ? '0 : (ld_rvalid  ? bus.mem_rdata : ld_rdata_q);
  assign dbg_rdata  = in_RST ? '0 : (dbg_rvalid ? bus.mem_rdata : dbg_rdata_q);

  always_ff @(posedge clk) begin
    if (in_RST) begin
      state_q     <= ARB;
      tag_q       <= GNT_NONE;
      pending_q   <= 1'b0;
      dbg_addr_q  <= '0;
      mem_addr_q  <= '0;
      ld_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      pending_q   <= pending_d;
      dbg_addr_q  <= dbg_addr_d;
      mem_addr_q  <= mem_addr;
      ld_rdata_q  <= ld_rdata;
      dbg_rdata_q <= dbg_rdata;
    end
  end

  assign bus.st_gnt     = st_gnt;
  assign bus.ld_gnt     = ld_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.pipe_stall = pipe_stall;
  assign bus.mem_we     = st_gnt;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = st_gnt ? bus.st_wdata : '0;
  assign bus.mem_half   = st_gnt && bus.st_half;
  assign bus.ld_rvalid  = ld_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  assign bus.ld_rdata   = ld_rdata;
  assign bus.dbg_rdata  = dbg_rdata;

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] force_cnt_q;

  always_ff @(posedge clk) begin
    if (in_RST) begin
      stall_cnt_q <= '0;
      force_cnt_q <= '0;
    end else begin
      if (pipe_stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (state_q == ARB && state_d == FORCE) begin
        force_cnt_q <= force_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign force_cnt = force_cnt_q;
`else
  assign stall_cnt = '0;
  assign force_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter (STARVE_MAX=3)
module tb_dmem_port_arbiter;

  logic        clk;
  logic        in_RST;
  logic [31:0] stall_cnt;
  logic [15:0] force_cnt;

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic        is_dbg;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  dmem_port_arbiter_if #(.AW(12), .DW(32)) bus ();

  dmem_port_arbiter #(
    .AW         (12),
    .DW         (32),
    .STARVE_MAX (3)
  ) dut (
    .clk       (clk),
    .in_RST    (in_RST),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt),
    .force_cnt (force_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [11:0] a);
    if (a == 12'h010) return 32'h0000_1234;
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  // DS model: read data for the presented address appears one cycle later.
  always @(posedge clk) bus.mem_rdata <= mem_fn(bus.mem_addr);

  // Scoreboard consumer: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (bus.ld_rvalid || bus.dbg_rvalid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_rvalid t=%0t ld_rvalid=%b dbg_rvalid=%b expected none", $time, bus.ld_rvalid, bus.dbg_rvalid);
      end else begin
        exp_t e;
        logic [31:0] got;
        e = exp_q.pop_front();
        got = e.is_dbg ? bus.dbg_rdata : bus.ld_rdata;
        if (bus.dbg_rvalid !== e.is_dbg || bus.ld_rvalid !== !e.is_dbg || got !== e.data) begin
          n_err++;
          $display("FAIL sb_read t=%0t got dbg=%b ld=%b data=%h expected dbg=%b data=%h", $time, bus.dbg_rvalid, bus.ld_rvalid, got, e.is_dbg, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.st_req   = 1'b0;
    bus.st_addr  = '0;
    bus.st_wdata = '0;
    bus.st_half  = 1'b0;
    bus.ld_req   = 1'b0;
    bus.ld_addr  = '0;
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = '0;
  endtask

  task automatic test_reset();
    cyc();
    bus.st_req  = 1'b1;
    bus.st_addr = 12'h055;
    #1;
    n_cmp++;
    if (bus.st_gnt !== 1'b0 || bus.mem_we !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.mem_addr !== 12'h000) begin
      n_err++;
      $display("FAIL reset_held got st_gnt=%b mem_we=%b stall=%b mem_addr=%h expected 0 0 0 000", bus.st_gnt, bus.mem_we, bus.pipe_stall, bus.mem_addr);
    end
    cyc();
    in_RST = 1'b0;
    idle_inputs();
    #1;
    n_cmp++;
    if ({bus.st_gnt, bus.ld_gnt, bus.dbg_gnt, bus.ld_rvalid, bus.dbg_rvalid, bus.mem_we, bus.mem_half, bus.pipe_stall} !== 8'h00
        || bus.mem_addr !== 12'h000 || bus.mem_wdata !== 32'h0 || bus.ld_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state got gnts=%b%b%b rv=%b%b we=%b addr=%h ldr=%h dbr=%h expected all zero",
               bus.st_gnt, bus.ld_gnt, bus.dbg_gnt, bus.ld_rvalid, bus.dbg_rvalid, bus.mem_we, bus.mem_addr, bus.ld_rdata, bus.dbg_rdata);
    end
    n_cmp++;
    if (stall_cnt !== 32'd0 || force_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_perf got stall_cnt=%0d force_cnt=%0d expected 0 0", stall_cnt, force_cnt);
    end
  endtask

  task automatic test_load();
    cyc();
    bus.ld_req  = 1'b1;
    bus.ld_addr = 12'h010;
    exp_q.push_back('{is_dbg: 1'b0, data: 32'h0000_1234});
    #1;
    n_cmp++;
    if (bus.ld_gnt !== 1'b1 || bus.pipe_stall !== 1'b0 || bus.mem_addr !== 12'h010 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL load_grant got ld_gnt=%b stall=%b mem_addr=%h mem_we=%b expected 1 0 010 0", bus.ld_gnt, bus.pipe_stall, bus.mem_addr, bus.mem_we);
    end
    cyc();
    bus.ld_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== 32'h0000_1234 || bus.ld_gnt !== 1'b0 || bus.mem_addr !== 12'h010) begin
      n_err++;
      $display("FAIL load_return got rvalid=%b rdata=%h ld_gnt=%b mem_addr=%h expected 1 00001234 0 010", bus.ld_rvalid, bus.ld_rdata, bus.ld_gnt, bus.mem_addr);
    end
    cyc();
    #1;
    n_cmp++;
    if (bus.ld_rvalid !== 1'b0 || bus.ld_rdata !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL load_hold got rvalid=%b rdata=%h expected 0 00001234", bus.ld_rvalid, bus.ld_rdata);
    end
  endtask

  task automatic test_store_load();
    cyc();
    bus.st_req   = 1'b1;
    bus.st_addr  = 12'h020;
    bus.st_wdata = 32'hDEAD_BEEF;
    bus.st_half  = 1'b1;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 12'h030;
    #1;
    n_cmp++;
    if (bus.st_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.ld_gnt !== 1'b0 || bus.pipe_stall !== 1'b1
        || bus.mem_addr !== 12'h020 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_half !== 1'b1) begin
      n_err++;
      $display("FAIL store_first got st_gnt=%b we=%b ld_gnt=%b stall=%b addr=%h wdata=%h half=%b expected 1 1 0 1 020 deadbeef 1",
               bus.st_gnt, bus.mem_we, bus.ld_gnt, bus.pipe_stall, bus.mem_addr, bus.mem_wdata, bus.mem_half);
    end
    cyc();
    bus.st_req  = 1'b0;
    bus.st_half = 1'b0;
    exp_q.push_back('{is_dbg: 1'b0, data: mem_fn(12'h030)});
    #1;
    n_cmp++;
    if (bus.ld_gnt !== 1'b1 || bus.pipe_stall !== 1'b0 || bus.mem_addr !== 12'h030 || bus.mem_we !== 1'b0 || bus.ld_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL load_after_store got ld_gnt=%b stall=%b addr=%h we=%b ld_rvalid=%b expected 1 0 030 0 0",
               bus.ld_gnt, bus.pipe_stall, bus.mem_addr, bus.mem_we, bus.ld_rvalid);
    end
    cyc();
    bus.ld_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== mem_fn(12'h030)) begin
      n_err++;
      $display("FAIL load_after_store_return got rvalid=%b rdata=%h expected 1 %h", bus.ld_rvalid, bus.ld_rdata, mem_fn(12'h030));
    end
  endtask

  task automatic test_debug_idle();
    cyc();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 12'h044;
    #1;
    n_cmp++;
    if (bus.dbg_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL dbg_capture_cycle got dbg_gnt=%b expected 0", bus.dbg_gnt);
    end
    cyc();
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = '0;
    exp_q.push_back('{is_dbg: 1'b1, data: mem_fn(12'h044)});
    #1;
    n_cmp++;
    if (bus.dbg_gnt !== 1'b1 || bus.mem_addr !== 12'h044 || bus.mem_half !== 1'b0 || bus.mem_we !== 1'b0 || bus.pipe_stall !== 1'b0) begin
      n_err++;
      $display("FAIL dbg_grant got dbg_gnt=%b addr=%h half=%b we=%b stall=%b expected 1 044 0 0 0", bus.dbg_gnt, bus.mem_addr, bus.mem_half, bus.mem_we, bus.pipe_stall);
    end
    cyc();
    #1;
    n_cmp++;
    if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== mem_fn(12'h044) || bus.dbg_gnt !== 1'b0 || bus.ld_rdata !== mem_fn(12'h030)) begin
      n_err++;
      $display("FAIL dbg_return got rvalid=%b rdata=%h dbg_gnt=%b ld_rdata=%h expected 1 %h 0 %h",
               bus.dbg_rvalid, bus.dbg_rdata, bus.dbg_gnt, bus.ld_rdata, mem_fn(12'h044), mem_fn(12'h030));
    end
    cyc();
    #1;
    n_cmp++;
    if (bus.dbg_gnt !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL dbg_pending_cleared got dbg_gnt=%b dbg_rvalid=%b expected 0 0", bus.dbg_gnt, bus.dbg_rvalid);
    end
  endtask

  // Continuous load traffic: each captured debug read is forced on the 5th cycle after capture.
  task automatic test_starve();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        logic [11:0] daddr;
        logic        want_dbg;
        daddr        = (r == 0) ? 12'h0AA : 12'h0BB;
        want_dbg     = (k == 5);
        cyc();
        bus.ld_req   = 1'b1;
        bus.ld_addr  = 12'h100;
        bus.dbg_req  = (k == 0);
        bus.dbg_addr = (k == 0) ? daddr : 12'h0EE;
        if (want_dbg) exp_q.push_back('{is_dbg: 1'b1, data: mem_fn(daddr)});
        else          exp_q.push_back('{is_dbg: 1'b0, data: mem_fn(12'h100)});
        #1;
        n_cmp++;
        if (bus.dbg_gnt !== want_dbg || bus.ld_gnt !== !want_dbg || bus.pipe_stall !== want_dbg
            || bus.mem_addr !== (want_dbg ? daddr : 12'h100)) begin
          n_err++;
          $display("FAIL starve r=%0d k=%0d got dbg_gnt=%b ld_gnt=%b stall=%b addr=%h expected %b %b %b %h",
                   r, k, bus.dbg_gnt, bus.ld_gnt, bus.pipe_stall, bus.mem_addr, want_dbg, !want_dbg, want_dbg, want_dbg ? daddr : 12'h100);
        end
      end
    end
    cyc();
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.ld_gnt !== 1'b0 || bus.dbg_gnt !== 1'b0 || bus.pipe_stall !== 1'b0) begin
      n_err++;
      $display("FAIL starve_tail got ld_gnt=%b dbg_gnt=%b stall=%b expected 0 0 0", bus.ld_gnt, bus.dbg_gnt, bus.pipe_stall);
    end
`ifdef DMEM_ARB_PERF_CNT_EN
    n_cmp++;
    if (stall_cnt !== 32'd3 || force_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL perf_counts got stall_cnt=%0d force_cnt=%0d expected 3 2", stall_cnt, force_cnt);
    end
`endif
  endtask

  task automatic test_dbg_first_wins();
    cyc();
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 12'h011;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 12'h044;
    exp_q.push_back('{is_dbg: 1'b0, data: mem_fn(12'h011)});
    cyc();
    bus.dbg_addr = 12'h0FF;
    exp_q.push_back('{is_dbg: 1'b0, data: mem_fn(12'h011)});
    #1;
    n_cmp++;
    if (bus.ld_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL first_wins_busy got ld_gnt=%b dbg_gnt=%b expected 1 0", bus.ld_gnt, bus.dbg_gnt);
    end
    cyc();
    bus.ld_req   = 1'b0;
    bus.dbg_addr = 12'h0FF;
    exp_q.push_back('{is_dbg: 1'b1, data: mem_fn(12'h044)});
    #1;
    n_cmp++;
    if (bus.dbg_gnt !== 1'b1 || bus.mem_addr !== 12'h044) begin
      n_err++;
      $display("FAIL first_wins_grant got dbg_gnt=%b addr=%h expected 1 044", bus.dbg_gnt, bus.mem_addr);
    end
    cyc();
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.dbg_rvalid !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL first_wins_return got dbg_rvalid=%b dbg_gnt=%b expected 1 0", bus.dbg_rvalid, bus.dbg_gnt);
    end
    cyc();
    #1;
    n_cmp++;
    if (bus.dbg_rvalid !== 1'b0 || bus.dbg_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL first_wins_single got dbg_rvalid=%b dbg_gnt=%b expected 0 0", bus.dbg_rvalid, bus.dbg_gnt);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    bus.ld_req  = 1'b1;
    bus.ld_addr = 12'h010;
    #1;
    n_cmp++;
    if (bus.ld_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_grant got ld_gnt=%b expected 1", bus.ld_gnt);
    end
    cyc();
    in_RST      = 1'b1;
    bus.ld_req  = 1'b0;
    #1;
    n_cmp++;
    if (bus.ld_rvalid !== 1'b0 || bus.ld_gnt !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.mem_addr !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mid_during got ld_rvalid=%b ld_gnt=%b stall=%b addr=%h expected 0 0 0 000", bus.ld_rvalid, bus.ld_gnt, bus.pipe_stall, bus.mem_addr);
    end
    cyc();
    in_RST = 1'b0;
    #1;
    n_cmp++;
    if (bus.ld_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0 || bus.ld_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0
        || bus.mem_addr !== 12'h000 || bus.mem_we !== 1'b0 || stall_cnt !== 32'd0 || force_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid_after got ld_rv=%b dbg_rv=%b ldr=%h dbr=%h addr=%h we=%b stall_cnt=%0d force_cnt=%0d expected all zero",
               bus.ld_rvalid, bus.dbg_rvalid, bus.ld_rdata, bus.dbg_rdata, bus.mem_addr, bus.mem_we, stall_cnt, force_cnt);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    in_RST = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_store_load();
    test_debug_idle();
    test_starve();
    test_dbg_first_wins();
    test_reset_mid();
    repeat (3) cyc();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d outstanding reads expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single data-memory port (DS) among three requesters: pipeline store (WB stage), pipeline load (MEM stage) and board debug read (switch address for the 7-seg display).
- Sits between the pipeline/display logic and DS, and replaces the ad-hoc WB/MEM address mux.
- Issues pipe_stall when a pipeline request loses arbitration.
- Guarantees debug reads forward progress with an aging counter.

Parameters:
- AW, 12, memory address width.
- DW, 32, data width.
- STARVE_MAX, 15, number of waiting cycles after which a pending debug read is force-granted (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- in_RST  in  1  synchronous reset, active-high.
- st_req  in  1  store request, level.
- st_addr  in  AW  store address.
- st_wdata  in  DW  store data.
- st_half  in  1  halfword store mode.
- ld_req  in  1  load request, level.
- ld_addr  in  AW  load address.
- dbg_req  in  1  debug read request, single-cycle pulse or level.
- dbg_addr  in  AW  debug address, sampled when dbg_req=1.
- st_gnt, ld_gnt, dbg_gnt  out  1 each  grant for this cycle; one-hot or zero.
- ld_rdata, dbg_rdata  out  DW  read data.
- ld_rvalid, dbg_rvalid  out  1  read data valid.
- mem_we  out  1  write enable to DS.
- mem_addr  out  AW  address to DS.
- mem_wdata  out  DW  write data to DS.
- mem_half  out  1  halfword mode to DS.
- mem_rdata  in  DW  DS read data, valid one cycle after a read address.
- pipe_stall  out  1  pipeline must hold (drives EN low).

Behaviour:
- Reset: all grants, rvalids, mem_we, mem_half and pipe_stall are 0; mem_addr, mem_wdata and rdata outputs are 0; pending cleared; age=0; state ARB.
- Debug capture: a cycle with dbg_req=1 and pending=0 sets pending=1 and latches dbg_addr.
  - dbg_req while pending=1 is ignored; the first address wins.
- Grants are combinational from the current request and state. Priority in state ARB: store > load > pending debug.
- Forcing a debug grant: when age==STARVE_MAX, the next cycle enters state FORCE.
  - In FORCE, dbg_gnt=1 and st_gnt=ld_gnt=0.
  - pipe_stall=1 if st_req or ld_req.
  - The state returns to ARB after one cycle.
- Age counter:
  - Clears on debug grant or reset.
  - Increments each cycle pending=1 without a grant.
  - Saturates at STARVE_MAX.
- pipe_stall=(st_req&~st_gnt)|(ld_req&~ld_gnt). Simultaneous store+load grants the store and stalls the load exactly one cycle.
- Memory port:
  - Store grant: mem_we=1, mem_addr=st_addr, mem_wdata=st_wdata, mem_half=st_half.
  - Load grant: mem_addr=ld_addr, mem_we=0.
  - Debug grant: mem_addr from the latched address, mem_half=0.
  - No grant: mem_we=0 and mem_addr holds its previous value.
- Read return: the grant tag is registered (GNT_LD/GNT_DBG/GNT_NONE).
  - Next cycle, the matching rvalid=1 and its rdata=mem_rdata. The other rdata holds its last value.
  - Store grants produce no rvalid.
- Pending clears on the same edge as the debug grant. A new dbg_req in the grant cycle is not captured.
- Reset asserted mid-transaction: the registered tag is cleared, and no rvalid is issued in the following cycle.

Optional Feature:
- Macro DMEM_ARB_PERF_CNT_EN.
- When defined:
  - Outputs stall_cnt[31:0] counts cycles with pipe_stall=1.
  - force_cnt[15:0] counts FORCE entries.
  - Both clear on in_RST and wrap on overflow; intended for display through change_type.
- When undefined: both ports still exist, are tied to 0, and no counter flops are synthesized.

Decomposition:
- Shared package/header:
  - Grant-tag constants GNT_NONE=2'd0, GNT_ST=2'd1, GNT_LD=2'd2, GNT_DBG=2'd3.
  - State constants ARB=1'b0, FORCE=1'b1.
  - Default widths AW/DW.
- One sub-module, dmem_age_counter: saturating counter with clear/increment and an at_max flag, parameterized by STARVE_MAX.

Test Plan:
- Reset, then ld_req=1, ld_addr=0x010 with mem_rdata=0x1234 next cycle -> ld_gnt=1 and pipe_stall=0 in cycle 0; ld_rvalid=1 and ld_rdata=0x1234 in cycle 1.
- st_req and ld_req together, st_addr=0x020, st_wdata=0xDEADBEEF:
  - Cycle 0: st_gnt=1, mem_we=1, ld_gnt=0, pipe_stall=1.
  - Cycle 1 with st_req=0: ld_gnt=1, pipe_stall=0.
- dbg_req pulse with dbg_addr=0x044 and an idle pipeline -> dbg_gnt=1 the next cycle with mem_addr=0x044; dbg_rvalid=1 the cycle after; pending then returns to 0.
- Continuous ld_req with dbg_req pulsed and STARVE_MAX=3:
  - dbg_gnt=1 on the 5th cycle after capture: age 0→3 takes 4 cycles, then FORCE.
  - pipe_stall=1 in that cycle only; age=0 afterwards.
- Second dbg_req with dbg_addr=0x0FF while pending with 0x044 -> the grant uses 0x044; exactly one dbg_rvalid is produced.
- in_RST asserted the cycle after ld_gnt -> ld_rvalid=0 the next cycle, all outputs at reset values; with DMEM_ARB_PERF_CNT_EN, stall_cnt=0.
